// File: rtl/i2s_rx.sv
// i2s_rx -- I2S responder. Deserialises an external BCK/WS/SD stream into
// parallel left/right PCM samples in the clk domain.
//
// Build option: define I2S_RX_FRAME_CHECK_EN to enable slot-length checking.
// When it is enabled, a bad slot pulses frame_err and the pair containing it
// is not delivered. When it is disabled, frame_err is tied low, short slots are
// zero-filled and long slots are truncated.
//
// Output strobe: sample_valid is a one-cycle strobe with no ready/backpressure.
// left_data/right_data change only in the strobe cycle and then hold until the
// next strobe, so a consumer may sample them in that cycle or at any later time.
module i2s_rx #(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  input  logic              i2s_bck,
  input  logic              i2s_ws,
  input  logic              i2s_sd,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              sample_valid,
  output logic              locked,
  output logic              frame_err
);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_t;

  localparam logic [5:0] DW_CNT = 6'(DATA_W);
  localparam logic [6:0] DW_LEN = 7'(DATA_W);

  // Synchronised pin copies
  logic bck_q1, bck_q2, bck_q3;
  logic ws_q1, ws_q2;
  logic sd_q1, sd_q2;

  logic rise;
  logic ws_prev;
  logic ws_change;

  state_t state, state_nxt;

  logic [5:0]        bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shift_in;
  logic [DATA_W-1:0] slot_bits;
  logic [DATA_W-1:0] slot_word;
  logic [DATA_W-1:0] left_hold;
  logic [6:0]        slot_len;
  logic [6:0]        pad;

  logic left_end;
  logic pair_end;
  logic pair_ok;

  // Two-flop synchronisers on every pin, plus a third bck stage for edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bck_q1 <= 1'b0;
      bck_q2 <= 1'b0;
      bck_q3 <= 1'b0;
      ws_q1  <= 1'b0;
      ws_q2  <= 1'b0;
      sd_q1  <= 1'b0;
      sd_q2  <= 1'b0;
    end else begin
      bck_q1 <= i2s_bck;
      bck_q2 <= bck_q1;
      bck_q3 <= bck_q2;
      ws_q1  <= i2s_ws;
      ws_q2  <= ws_q1;
      sd_q1  <= i2s_sd;
      sd_q2  <= sd_q1;
    end
  end

  assign rise      = bck_q2 & ~bck_q3;
  assign ws_change = rise & (ws_q2 != ws_prev);

  // Close the current slot: append the present bit (it still belongs to the
  // old slot because of the one-bit WS lead) and left-justify short slots
  always_comb begin
    shift_in  = {shreg[DATA_W-2:0], sd_q2};
    slot_bits = (bit_cnt < DW_CNT) ? shift_in : shreg;
    slot_len  = {1'b0, bit_cnt} + 7'd1;
    pad       = '0;
    if (slot_len < DW_LEN) pad = DW_LEN - slot_len;
    slot_word = slot_bits << pad;
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_SYNC;
    else       state <= state_nxt;
  end

  // FSM next state: slot boundaries are the only transitions; ena low forces SYNC
  always_comb begin
    state_nxt = state;
    if (!ena) begin
      state_nxt = ST_SYNC;
    end else if (ws_change) begin
      unique case (state)
        ST_SYNC:  if (!ws_q2) state_nxt = ST_LEFT;
        ST_LEFT:  if (ws_q2)  state_nxt = ST_RIGHT;
        ST_RIGHT: if (!ws_q2) state_nxt = ST_LEFT;
        default:  state_nxt = ST_SYNC;
      endcase
    end
  end

  // FSM outputs: lock indication and the two slot-end events
  always_comb begin
    locked   = (state != ST_SYNC);
    left_end = ena & ws_change & (state == ST_LEFT)  & ws_q2;
    pair_end = ena & ws_change & (state == ST_RIGHT) & ~ws_q2;
  end

  // WS history, bit counter and MSB-first shifter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ws_prev <= 1'b0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      if (rise) ws_prev <= ws_q2;
      if (!ena) begin
        bit_cnt <= '0;
        shreg   <= '0;
      end else if (rise) begin
        if (ws_change) begin
          bit_cnt <= '0;
          shreg   <= '0;
        end else begin
          if (bit_cnt < DW_CNT)  shreg   <= shift_in;
          if (bit_cnt != 6'd63)  bit_cnt <= bit_cnt + 6'd1;
        end
      end
    end
  end

  // Left word holding and registered delivery of the completed pair
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      left_hold    <= '0;
      left_data    <= '0;
      right_data   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (left_end) left_hold <= slot_word;
      if (pair_end && pair_ok) begin
        left_data    <= left_hold;
        right_data   <= slot_word;
        sample_valid <= 1'b1;
      end
    end
  end

`ifdef I2S_RX_FRAME_CHECK_EN
  logic [6:0] left_len;
  logic       left_bad;
  logic       len_err;
  logic       right_err;

  // Slot-length rules; a bad left slot also spoils the pair that follows it
  always_comb begin
    len_err   = (slot_len < DW_LEN) || (slot_len > 7'd32);
    right_err = len_err || (slot_len != left_len);
    pair_ok   = !(left_bad || right_err);
  end

  // Remember the left slot's length/health and pulse frame_err per bad slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      left_len  <= '0;
      left_bad  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (left_end) begin
        left_len  <= slot_len;
        left_bad  <= len_err;
        frame_err <= len_err;
      end
      if (pair_end) frame_err <= right_err;
    end
  end
`else
  assign pair_ok   = 1'b1;
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx -- directed bench for i2s_rx at the minimum clk:BCK ratio of 4.
// Frame-check expectations follow the I2S_RX_FRAME_CHECK_EN build option.
`timescale 1ns/1ps
module tb_i2s_rx;

  localparam int DATA_W = 24;
  localparam int HALF   = 2;  // clk periods per BCK phase (4x ratio)
  // sample_valid is visible in the 4th clk period counting the one in which
  // BCK rose: three posedges after the negedge that raised BCK.
  localparam int LAT    = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              ena;
  logic              i2s_bck;
  logic              i2s_ws;
  logic              i2s_sd;
  logic [DATA_W-1:0] left_data;
  logic [DATA_W-1:0] right_data;
  logic              sample_valid;
  logic              locked;
  logic              frame_err;

  int chk = 0;
  int err = 0;

  int cyc        = 0;
  int rise_cyc   = 0;
  int valid_cnt  = 0;
  int ferr_cnt   = 0;
  int glitch_cnt = 0;
  int lat        = 0;
  logic [DATA_W-1:0] cap_l  = '0;
  logic [DATA_W-1:0] cap_r  = '0;
  logic [DATA_W-1:0] prev_l = '0;
  logic [DATA_W-1:0] prev_r = '0;
  logic [DATA_W-1:0] exp_l  = '0;
  logic [DATA_W-1:0] exp_r  = '0;

  i2s_rx #(.DATA_W(DATA_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .ena          (ena),
    .i2s_bck      (i2s_bck),
    .i2s_ws       (i2s_ws),
    .i2s_sd       (i2s_sd),
    .left_data    (left_data),
    .right_data   (right_data),
    .sample_valid (sample_valid),
    .locked       (locked),
    .frame_err    (frame_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- monitor (samples on the falling edge) ----------------
  always @(negedge clk) begin
    if (sample_valid) begin
      valid_cnt++;
      cap_l = left_data;
      cap_r = right_data;
      lat   = cyc - rise_cyc;
    end
    if (frame_err) ferr_cnt++;
    if (!reset && !sample_valid && (left_data !== prev_l || right_data !== prev_r))
      glitch_cnt++;
    prev_l = left_data;
    prev_r = right_data;
  end

  // ---------------- check ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // One bit: WS/SD change with the BCK fall, receiver samples on the BCK rise
  task automatic send_bit(input logic w, input logic d);
    i2s_bck = 1'b0;
    i2s_ws  = w;
    i2s_sd  = d;
    repeat (HALF) @(negedge clk);
    i2s_bck  = 1'b1;
    rise_cyc = cyc;
    repeat (HALF) @(negedge clk);
  endtask

  // A slot MSB first; its LSB already carries the next slot's WS
  task automatic send_slot(input logic w, input logic [63:0] v, input int len, input logic nxt);
    for (int i = len - 1; i >= 1; i--) send_bit(w, v[i]);
    send_bit(nxt, v[0]);
  endtask

  task automatic send_frame(input logic [63:0] l, input logic [63:0] r,
                            input int len_l, input int len_r);
    send_slot(1'b0, l, len_l, 1'b1);
    send_slot(1'b1, r, len_r, 1'b0);
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  // One new pair delivered with the given data and the fixed latency
  task automatic expect_pair(input string tag, input int base,
                             input logic [DATA_W-1:0] el, input logic [DATA_W-1:0] er);
    check({tag, "_cnt"},   64'(valid_cnt), 64'(base + 1));
    check({tag, "_left"},  64'(cap_l), 64'(el));
    check({tag, "_right"}, 64'(cap_r), 64'(er));
    check({tag, "_lat"},   64'(lat), 64'(LAT));
    check({tag, "_hold"},  {left_data, right_data}, {el, er});
    exp_l = el;
    exp_r = er;
  endtask

  // Error frame: no delivery, outputs untouched, given number of frame_err pulses
  task automatic expect_reject(input string tag, input int base, input int fbase, input int n);
    check({tag, "_cnt"},  64'(valid_cnt), 64'(base));
    check({tag, "_ferr"}, 64'(ferr_cnt), 64'(fbase + n));
    check({tag, "_hold"}, {left_data, right_data}, {exp_l, exp_r});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int fbase;
    int len;
    logic [63:0] lv;
    logic [63:0] rv;

    reset   = 1'b1;
    ena     = 1'b1;
    i2s_bck = 1'b0;
    i2s_ws  = 1'b0;
    i2s_sd  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_left",   64'(left_data), 64'h0);
    check("rst_right",  64'(right_data), 64'h0);
    check("rst_valid",  64'(sample_valid), 64'h0);
    check("rst_locked", 64'(locked), 64'h0);
    check("rst_ferr",   64'(frame_err), 64'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_locked", 64'(locked), 64'h0);

    // Stream starts mid-right-slot: partial slot discarded, lock on 1->0
    send_slot(1'b1, 64'h2AB, 11, 1'b0);
    settle();
    check("midr_valid",  64'(valid_cnt), 64'h0);
    check("midr_locked", 64'(locked), 64'h1);

    // 32-bit slots into a 24-bit sample
    base = valid_cnt;
    send_frame(64'hA5A5A55A, 64'h3C3C3CC3, 32, 32);
    settle();
    expect_pair("s32", base, 24'hA5A5A5, 24'h3C3C3C);
    check("s32_locked", 64'(locked), 64'h1);

    // 16-bit slots
    base  = valid_cnt;
    fbase = ferr_cnt;
    send_frame(64'h1234, 64'hABCD, 16, 16);
    settle();
`ifdef I2S_RX_FRAME_CHECK_EN
    expect_reject("s16", base, fbase, 2);
`else
    expect_pair("s16", base, 24'h123400, 24'hABCD00);
`endif

    // Left 32 / right 24: lengths disagree
    base  = valid_cnt;
    fbase = ferr_cnt;
    send_frame(64'hDEADBEEF, 64'h13579B, 32, 24);
    settle();
`ifdef I2S_RX_FRAME_CHECK_EN
    expect_reject("mism", base, fbase, 1);
`else
    expect_pair("mism", base, 24'hDEADBE, 24'h13579B);
`endif

    // 40-bit slots: longer than 32
    base  = valid_cnt;
    fbase = ferr_cnt;
    send_frame(64'h123456789A, 64'hFEDCBA9876, 40, 40);
    settle();
`ifdef I2S_RX_FRAME_CHECK_EN
    expect_reject("s40", base, fbase, 2);
`else
    expect_pair("s40", base, 24'h123456, 24'hFEDCBA);
`endif

    // Exactly DATA_W bits per slot: delivered in both builds
    base = valid_cnt;
    send_frame(64'h800001, 64'h7FFFFE, 24, 24);
    settle();
    expect_pair("s24", base, 24'h800001, 24'h7FFFFE);

    // ena dropped mid-left-slot
    base = valid_cnt;
    for (int i = 0; i < 16; i++) send_bit(1'b0, 1'b1);
    ena = 1'b0;
    @(negedge clk);
    check("ena_locked_fall", 64'(locked), 64'h0);
    repeat (3) @(negedge clk);
    check("ena_hold", {left_data, right_data}, {exp_l, exp_r});
    ena = 1'b1;
    for (int i = 0; i < 15; i++) send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    settle();
    check("ena_still_sync", 64'(locked), 64'h0);
    send_slot(1'b1, 64'hCAFE0000, 32, 1'b0);
    settle();
    check("ena_no_valid", 64'(valid_cnt), 64'(base));
    check("ena_relock",   64'(locked), 64'h1);
    send_frame(64'h0F0F0F00, 64'hF0F0F0FF, 32, 32);
    settle();
    expect_pair("ena_next", base, 24'h0F0F0F, 24'hF0F0F0);

    // reset asserted mid-right-slot
    base = valid_cnt;
    send_slot(1'b0, 64'h11111111, 32, 1'b1);
    for (int i = 0; i < 16; i++) send_bit(1'b1, 1'b0);
    reset = 1'b1;
    #1;
    check("mrst_data",   {left_data, right_data}, 64'h0);
    check("mrst_valid",  64'(sample_valid), 64'h0);
    check("mrst_locked", 64'(locked), 64'h0);
    check("mrst_ferr",   64'(frame_err), 64'h0);
    exp_l = '0;
    exp_r = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 15; i++) send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    settle();
    check("mrst_no_valid", 64'(valid_cnt), 64'(base));
    check("mrst_relock",   64'(locked), 64'h1);
    send_frame(64'h2468ACE0, 64'h13579BDF, 32, 32);
    settle();
    expect_pair("mrst_next", base, 24'h2468AC, 24'h13579B);

    // Random legal frames, slot length DATA_W..32, at the 4x ratio
    for (int f = 0; f < 150; f++) begin
      base = valid_cnt;
      len  = $urandom_range(32, 24);
      lv   = 64'($urandom) & ((64'd1 << len) - 64'd1);
      rv   = 64'($urandom) & ((64'd1 << len) - 64'd1);
      send_frame(lv, rv, len, len);
      settle();
      expect_pair("rand", base, 24'(lv >> (len - 24)), 24'(rv >> (len - 24)));
    end

    check("data_stable", 64'(glitch_cnt), 64'h0);
`ifndef I2S_RX_FRAME_CHECK_EN
    check("ferr_tied", 64'(ferr_cnt), 64'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule
